// File: rtl/isqrt_pkg.sv
// Shared widths and depth for the pipelined integer square root.
// Every isqrt_* file imports this package so the datapath widths stay consistent.
package isqrt_pkg;

   localparam int ISQRT_X_W    = 32;
   localparam int ISQRT_Y_W    = 16;
   localparam int ISQRT_REM_W  = 18;
   localparam int ISQRT_STAGES = 16;

   typedef logic [ISQRT_X_W-1:0]   rad_t;
   typedef logic [ISQRT_Y_W-1:0]   root_t;
   typedef logic [ISQRT_REM_W-1:0] rem_t;

endpackage : isqrt_pkg

// File: rtl/isqrt_stage.sv
// One digit-by-digit square root step: resolves one root bit from the next two radicand bits.
// Only the valid flag is reset; the data registers load solely on an incoming valid.
module isqrt_stage
   import isqrt_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_vld,
   input  logic [ISQRT_Y_W-1:0]   in_root,
   input  logic [ISQRT_REM_W-1:0] in_rem,
   input  logic [ISQRT_X_W-1:0]   in_rad,
   output logic                   out_vld,
   output logic [ISQRT_Y_W-1:0]   out_root,
   output logic [ISQRT_REM_W-1:0] out_rem,
   output logic [ISQRT_X_W-1:0]   out_rad
);

   rem_t  rem_shift_s;
   rem_t  trial_s;
   rem_t  diff_s;
   logic  fits_s;
   rem_t  nxt_rem_s;
   root_t nxt_root_s;
   rad_t  nxt_rad_s;

   logic  vld_r;
   root_t root_r;
   rem_t  rem_r;
   rad_t  rad_r;

   // Trial subtraction: bring down two radicand bits and test against (root<<2)|1.
   always_comb begin
      rem_shift_s = (in_rem << 2) | {{(ISQRT_REM_W-2){1'b0}}, in_rad[ISQRT_X_W-1 -: 2]};
      trial_s     = {in_root, 2'b01};
      diff_s      = rem_shift_s - trial_s;
      fits_s      = (rem_shift_s >= trial_s);
      nxt_rad_s   = in_rad << 2;
   end

   // Select the new root bit and remainder from the trial outcome.
   always_comb begin
      nxt_rem_s  = rem_shift_s;
      nxt_root_s = in_root << 1;
      if (fits_s) begin
         nxt_rem_s  = diff_s;
         nxt_root_s = (in_root << 1) | {{(ISQRT_Y_W-1){1'b0}}, 1'b1};
      end else begin
         nxt_rem_s  = rem_shift_s;
         nxt_root_s = in_root << 1;
      end
   end

   // Valid flag moves every cycle and is the only state cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_r <= 1'b0;
      end else begin
         vld_r <= in_vld;
      end
   end

   // Data registers capture only for a live argument.
   always_ff @(posedge clk) begin
      if (in_vld) begin
         root_r <= nxt_root_s;
         rem_r  <= nxt_rem_s;
         rad_r  <= nxt_rad_s;
      end
   end

   assign out_vld  = vld_r;
   assign out_root = root_r;
   assign out_rem  = rem_r;
   assign out_rad  = rad_r;

endmodule : isqrt_stage

// File: rtl/isqrt_pipe.sv
// Fully pipelined floor(sqrt(x)) for 32-bit unsigned x: sixteen stages, one root bit each.
// Fixed 16-cycle latency, one argument per cycle, no backpressure.
module isqrt_pipe
   import isqrt_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 x_vld,
   input  logic [ISQRT_X_W-1:0] x,
   output logic                 y_vld,
   output logic [ISQRT_Y_W-1:0] y
);

   logic  vld_s  [0:ISQRT_STAGES];
   root_t root_s [0:ISQRT_STAGES];
   rem_t  rem_s  [0:ISQRT_STAGES];
   rad_t  rad_s  [0:ISQRT_STAGES];

   assign vld_s[0]  = x_vld;
   assign root_s[0] = {ISQRT_Y_W{1'b0}};
   assign rem_s[0]  = {ISQRT_REM_W{1'b0}};
   assign rad_s[0]  = x;

   for (genvar i = 0; i < ISQRT_STAGES; i++) begin : g_stage
      isqrt_stage u_stage (
         .clk      (clk),
         .rst      (rst),
         .in_vld   (vld_s[i]),
         .in_root  (root_s[i]),
         .in_rem   (rem_s[i]),
         .in_rad   (rad_s[i]),
         .out_vld  (vld_s[i+1]),
         .out_root (root_s[i+1]),
         .out_rem  (rem_s[i+1]),
         .out_rad  (rad_s[i+1])
      );
   end

   // Outputs come straight from the last stage registers.
   assign y_vld = vld_s[ISQRT_STAGES];
   assign y     = root_s[ISQRT_STAGES];

endmodule : isqrt_pipe

// File: tb/tb_isqrt_pipe.sv
// Directed and random checks for isqrt_pipe: latency, ordering, gaps, reset flush, exactness.
// A 16-entry expectation pipe holds hand-computed or reference results per issued cycle.
module tb_isqrt_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        x_vld;
   logic [31:0] x;
   logic        y_vld;
   logic [15:0] y;

   int checks = 0;
   int errors = 0;

   logic        ev [0:15];
   logic [15:0] ey [0:15];
   logic [31:0] ex [0:15];

   always #5 clk = ~clk;

   isqrt_pipe dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y)
   );

   function automatic logic [15:0] ref_sqrt(input logic [31:0] a);
      longint av;
      longint r;
      av = longint'({32'd0, a});
      r  = longint'($sqrt(real'(av)));
      while (r * r > av) r = r - 64'sd1;
      while ((r + 64'sd1) * (r + 64'sd1) <= av) r = r + 64'sd1;
      return r[15:0];
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         ev[i] = 1'b0;
         ey[i] = 16'd0;
         ex[i] = 32'd0;
      end
   endtask

   // Drive one cycle of input, advance the expectation pipe, check what emerges.
   task automatic cycle(input logic v, input logic [31:0] xv, input logic [15:0] eyv);
      longint yy;
      longint xx;
      logic   bounds_ok;
      x_vld = v;
      x     = xv;
      @(posedge clk);
      #1;
      for (int i = 15; i > 0; i--) begin
         ev[i] = ev[i-1];
         ey[i] = ey[i-1];
         ex[i] = ex[i-1];
      end
      ev[0] = v;
      ey[0] = eyv;
      ex[0] = xv;
      check_bit("y_vld", y_vld, ev[15]);
      if (ev[15]) begin
         check_val("y", {16'd0, y}, {16'd0, ey[15]});
         yy = longint'({48'd0, y});
         xx = longint'({32'd0, ex[15]});
         bounds_ok = (yy * yy <= xx) && ((yy + 64'sd1) * (yy + 64'sd1) > xx);
         check_bit("y_bounds", bounds_ok, 1'b1);
      end
   endtask

   initial begin
      logic [31:0] rv;
      rst   = 1'b1;
      x_vld = 1'b0;
      x     = 32'd0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check_bit("reset_y_vld", y_vld, 1'b0);
      rst = 1'b0;

      // Isolated single arguments with idle gaps.
      cycle(1'b1, 32'd0, 16'd0);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);
      cycle(1'b1, 32'd1, 16'd1);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);
      cycle(1'b1, 32'd15, 16'd3);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);
      cycle(1'b1, 32'd16, 16'd4);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);

      // Top-of-range boundaries, back to back.
      cycle(1'b1, 32'hFFFF_FFFF, 16'hFFFF);
      cycle(1'b1, 32'hFFFE_0001, 16'hFFFF);
      cycle(1'b1, 32'hFFFE_0000, 16'hFFFE);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);

      // Three consecutive arguments.
      cycle(1'b1, 32'd9, 16'd3);
      cycle(1'b1, 32'd100, 16'd10);
      cycle(1'b1, 32'd1000000, 16'd1000);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);

      // Gap must be preserved.
      cycle(1'b1, 32'd4, 16'd2);
      cycle(1'b0, 32'd0, 16'd0);
      cycle(1'b1, 32'd25, 16'd5);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);

      // Stream 20 perfect squares, then reset while results are emerging.
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b1, 32'(k * k), 16'(k));
      end
      check_bit("pre_rst_y_vld", y_vld, 1'b1);
      #2;
      rst   = 1'b1;
      x_vld = 1'b0;
      #1;
      check_bit("rst_async_y_vld", y_vld, 1'b0);
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check_bit("rst_hold_y_vld", y_vld, 1'b0);
      rst = 1'b0;
      repeat (20) cycle(1'b0, 32'd0, 16'd0);
      cycle(1'b1, 32'd49, 16'd7);
      repeat (18) cycle(1'b0, 32'd0, 16'd0);

      // Random back-to-back stream against the reference model.
      for (int n = 0; n < 10000; n++) begin
         rv = $urandom;
         cycle(1'b1, rv, ref_sqrt(rv));
      end
      repeat (18) cycle(1'b0, 32'd0, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_isqrt_pipe
